// File: rtl/alu_pipe.sv
// Handshaked, registered ALU: single-cycle logic/arith/shift/compare ops plus an
// iterative shift-add multiply that retires one multiplier bit per clock.
module alu_pipe #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SIGNED_CMP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             overflow,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = SH_W;
  localparam int unsigned PW    = 2 * WIDTH;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   xq_q, xq_d;
  logic [WIDTH-1:0]   yq_q, yq_d;
  logic [WIDTH-1:0]   z_d;
  logic               carry_d, overflow_d, lt_d, eq_d, gt_d, out_valid_d;

  logic               accept;
  logic [WIDTH:0]     sum_add, sum_sub;
  logic [SH_W-1:0]    shamt;
  logic [2:0]         cmp_in, cmp_cap;
  logic [WIDTH-1:0]   alu_z;
  logic               alu_c, alu_v;
  logic [PW-1:0]      acc_step;

  // {lt, eq, gt} for a pair of operands in the configured compare mode
  function automatic logic [2:0] cmp3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic less;
    if (SIGNED_CMP != 0) less = ($signed(a) < $signed(b));
    else                 less = (a < b);
    return {less, (a == b), (!less && (a != b))};
  endfunction

  assign in_ready = rst_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  assign sum_add  = {1'b0, x} + {1'b0, y};
  assign sum_sub  = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
  assign shamt    = y[SH_W-1:0];
  assign cmp_in   = cmp3(x, y);
  assign cmp_cap  = cmp3(xq_q, yq_q);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : PW'(0));

  // Single-cycle result for every op except MUL
  always_comb begin
    alu_z = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_AND: alu_z = x & y;
      OP_OR:  alu_z = x | y;
      OP_ADD: begin
        alu_z = sum_add[WIDTH-1:0];
        alu_c = sum_add[WIDTH];
        alu_v = (x[WIDTH-1] == y[WIDTH-1]) && (sum_add[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        alu_z = sum_sub[WIDTH-1:0];
        alu_c = sum_sub[WIDTH];
        alu_v = (x[WIDTH-1] != y[WIDTH-1]) && (sum_sub[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SLL: alu_z = x << shamt;
      OP_SRL: alu_z = x >> shamt;
      OP_SLT: alu_z = WIDTH'(cmp_in[2]);
      default: alu_z = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    xq_d        = xq_q;
    yq_d        = yq_q;
    z_d         = z;
    carry_d     = carry;
    overflow_d  = overflow;
    lt_d        = lt;
    eq_d        = eq;
    gt_d        = gt;
    out_valid_d = out_valid;

    if ((state_q == S_DONE) && out_ready) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end

    if (state_q == S_MUL) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_STEP) begin
        state_d              = S_DONE;
        out_valid_d          = 1'b1;
        z_d                  = acc_step[WIDTH-1:0];
        carry_d              = |acc_step[PW-1:WIDTH];
        overflow_d           = 1'b0;
        {lt_d, eq_d, gt_d}   = cmp_cap;
      end
    end

    // Accept overrides the DONE->IDLE drain so back-to-back ops see no bubble
    if (accept) begin
      xq_d = x;
      yq_d = y;
      if (op == OP_MUL) begin
        state_d     = S_MUL;
        out_valid_d = 1'b0;
        cnt_d       = '0;
        acc_d       = '0;
        mcand_d     = {{WIDTH{1'b0}}, x};
        mplier_d    = y;
      end else begin
        state_d            = S_DONE;
        out_valid_d        = 1'b1;
        z_d                = alu_z;
        carry_d            = alu_c;
        overflow_d         = alu_v;
        {lt_d, eq_d, gt_d} = cmp_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      xq_q      <= '0;
      yq_q      <= '0;
      z         <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      xq_q      <= xq_d;
      yq_q      <= yq_d;
      z         <= z_d;
      carry     <= carry_d;
      overflow  <= overflow_d;
      lt        <= lt_d;
      eq        <= eq_d;
      gt        <= gt_d;
      out_valid <= out_valid_d;
    end
  end

endmodule
